adc128s_fc: RTL and testbench

Behavioral model of an ADC128S-family 8-channel, 12-bit SPI A2D converter, used on the A2D SPI bus of the Segway system bench. It serves conversions for four analog sources: left load cell, right load cell, steering potentiometer and battery. The bus master is the DUT's A2D interface. Each SPI frame carries a channel command in. The reply for that command is shifted out in the next frame.

---
 rtl/adc128s_pkg.sv | 20 ++
 rtl/adc128s_fc_sync.sv | 46 ++++
 rtl/adc128s_fc.sv | 83 ++++++++
 tb/tb_adc128s_fc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/adc128s_pkg.sv
// Shared constants and types for the ADC128S-family SPI A2D behavioural model.
package adc128s_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned CNT_W      = 5;

    // Channel field position inside the received command word
    localparam int unsigned CH_MSB = 13;
    localparam int unsigned CH_LSB = 11;

    typedef logic [CH_W-1:0] chnl_t;

    localparam chnl_t CH_LD_LFT  = 3'd0;
    localparam chnl_t CH_LD_RGHT = 3'd4;
    localparam chnl_t CH_STEER   = 3'd5;
    localparam chnl_t CH_BATT    = 3'd6;

endpackage

// File: rtl/adc128s_fc_sync.sv
// Pin synchronizers and edge detectors for the SPI slave inputs.
module spi_slv_sync (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic ss_fall,
    output logic ss_rise,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s
);

    // [0] metastability flop, [1] synchronized value, [2] history for edge detect
    logic [2:0] ss_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    // Edges are held off until the chains hold real pin values, so a pin that
    // is mid-frame when reset releases does not look like a fresh edge.
    logic [1:0] settle;
    logic       live;

    // Synchronizer chains, reset to the idle bus state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
            settle <= 2'd0;
        end else begin
            ss_q   <= {ss_q[1:0], SS_n};
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    assign live      = (settle == 2'd3);
    assign ss_fall   = live &  ss_q[2]   & ~ss_q[1];
    assign ss_rise   = live & ~ss_q[2]   &  ss_q[1];
    assign sclk_rise = live & ~sclk_q[2] &  sclk_q[1];
    assign sclk_fall = live &  sclk_q[2] & ~sclk_q[1];
    assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/adc128s_fc.sv
// ADC128S-style 8-channel SPI A2D model: reply to a command in the next frame.
module adc128s_fc
    import adc128s_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] ld_cell_lft,
    input  logic [DATA_W-1:0] ld_cell_rght,
    input  logic [DATA_W-1:0] steerPot,
    input  logic [DATA_W-1:0] batt
);

    // Only the bits up to the channel field's MSB ever get decoded
    localparam int unsigned RX_W = CH_MSB + 1;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    chnl_t                 chnl;
    logic [FRAME_BITS-1:0] shft;
    logic [RX_W-1:0]       rx;
    logic [CNT_W-1:0]      count;
    logic                  frame_act;
    logic [DATA_W-1:0]     sel_val;

    spi_slv_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_s    (mosi_s)
    );

    // Channel mux; unpopulated channels read as zero
    always_comb begin
        sel_val = '0;
        case (chnl)
            CH_LD_LFT:  sel_val = ld_cell_lft;
            CH_LD_RGHT: sel_val = ld_cell_rght;
            CH_STEER:   sel_val = steerPot;
            CH_BATT:    sel_val = batt;
            default:    sel_val = '0;
        endcase
    end

    // Frame engine: snapshot at SS_n fall, shift/receive, decode at SS_n rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chnl      <= CH_LD_LFT;
            shft      <= '0;
            rx        <= '0;
            count     <= '0;
            frame_act <= 1'b0;
        end else if (ss_fall) begin
            frame_act <= 1'b1;
            shft      <= {{(FRAME_BITS-DATA_W){1'b0}}, sel_val};
            count     <= '0;
        end else if (frame_act) begin
            if (ss_rise) begin
                frame_act <= 1'b0;
                if (count == CNT_W'(FRAME_BITS)) chnl <= rx[CH_MSB:CH_LSB];
            end else begin
                if (sclk_rise) begin
                    rx <= {rx[RX_W-2:0], mosi_s};
                    if (count != '1) count <= count + CNT_W'(1);
                end
                if (sclk_fall) shft <= {shft[FRAME_BITS-2:0], mosi_s};
            end
        end
    end

    // MISO only driven inside an accepted frame
    assign MISO = frame_act ? shft[FRAME_BITS-1] : 1'bz;

endmodule

// File: tb/tb_adc128s_fc.sv
// Self-checking bench for adc128s_fc: directed table, corner sequences, random frames.
module tb_adc128s_fc;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n, sclk, mosi;
    wire         miso;
    logic [11:0] lft, rght, steer, batt;

    int checks   = 0;
    int failures = 0;
    int exp_ch   = 0;

    pullup (miso);

    always #5 clk = ~clk;

    adc128s_fc dut (
        .clk          (clk),
        .rst          (rst),
        .SS_n         (ss_n),
        .SCLK         (sclk),
        .MOSI         (mosi),
        .MISO         (miso),
        .ld_cell_lft  (lft),
        .ld_cell_rght (rght),
        .steerPot     (steer),
        .batt         (batt)
    );

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp;
    } vec_t;

    // Reference: value a channel number reads, given the analog snapshot
    function automatic logic [15:0] ref_reply(input int ch, input logic [11:0] a0,
                                              input logic [11:0] a4, input logic [11:0] a5,
                                              input logic [11:0] a6);
        logic [11:0] amap [8];
        for (int k = 0; k < 8; k++) amap[k] = 12'h000;
        amap[0] = a0; amap[4] = a4; amap[5] = a5; amap[6] = a6;
        return {4'h0, amap[ch]};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Master-side frame: nbits SCLK periods, MISO sampled on each SCLK rise
    task automatic frame(input logic [15:0] cmd, input int nbits, input bit chg,
                         output logic [15:0] reply);
        logic [16:0] r;
        r = '0;
        @(negedge clk) ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) mosi = cmd[15-i];
            else        mosi = 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            r = {r[15:0], miso};
            repeat (HALF) @(negedge clk);
            if (chg && i == 8) begin
                lft = 12'($urandom); rght = 12'($urandom);
                steer = 12'($urandom); batt = 12'($urandom);
            end
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (HALF) @(negedge clk);
        if (nbits > 16) reply = r[16:1];
        else            reply = r[15:0] << (16 - nbits);
    endtask

    // Run one frame through the reference and compare the overlapping bits
    task automatic model_frame(input string nm, input logic [15:0] cmd, input int nbits,
                               input bit chg);
        logic [15:0] exp, rep, mask;
        int          nb;
        exp  = ref_reply(exp_ch, lft, rght, steer, batt);
        frame(cmd, nbits, chg, rep);
        nb   = (nbits > 16) ? 16 : nbits;
        mask = 16'hFFFF << (16 - nb);
        check(nm, rep & mask, exp & mask);
        check({nm, "_idle_z"}, {15'h0, miso}, 16'h0001);
        if (nbits == 16) exp_ch = int'(cmd[13:11]);
    endtask

    initial begin
        vec_t        vt [10];
        logic [15:0] rep;
        int          sel;

        rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        lft = 12'hABC; rght = 12'h123; steer = 12'h800; batt = 12'hFFF;
        repeat (3) @(negedge clk);
        check("reset_miso_z", {15'h0, miso}, 16'h0001);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_miso_z", {15'h0, miso}, 16'h0001);

        // Directed sequence: command in one frame, its data in the next
        vt[0] = '{16'h0000, 16'h0ABC};
        vt[1] = '{16'h0000, 16'h0ABC};
        vt[2] = '{16'h2000, 16'h0ABC};
        vt[3] = '{16'h0000, 16'h0123};
        vt[4] = '{16'h0000, 16'h0ABC};
        vt[5] = '{16'h2800, 16'h0ABC};
        vt[6] = '{16'h3000, 16'h0800};
        vt[7] = '{16'h0000, 16'h0FFF};
        vt[8] = '{16'h3800, 16'h0ABC};
        vt[9] = '{16'h0000, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            frame(vt[i].cmd, 16, 1'b0, rep);
            check($sformatf("table%0d", i), rep, vt[i].exp);
            check($sformatf("table%0d_idle_z", i), {15'h0, miso}, 16'h0001);
        end

        // Short frame must not change the selected channel
        frame(16'h2800, 16, 1'b0, rep);
        check("short_setup", rep, 16'h0ABC);
        frame(16'h2000, 8, 1'b0, rep);
        check("short_reply_top", rep & 16'hFF00, 16'h0800 & 16'hFF00);
        frame(16'h0000, 16, 1'b0, rep);
        check("short_keeps_chnl", rep, 16'h0800);

        // Reset in the middle of a frame
        frame(16'h3000, 16, 1'b0, rep);
        check("rst_setup", rep, 16'h0ABC);
        @(negedge clk) ss_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mosi = 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("mid_frame_driven", {15'h0, miso}, 16'h0000);
        rst = 1'b1;
        #1;
        check("rst_miso_z", {15'h0, miso}, 16'h0001);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            mosi = (i == 0 || i == 1) ? 1'b1 : 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (i == 6) check("aborted_frame_z", {15'h0, miso}, 16'h0001);
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (HALF) @(negedge clk);
        exp_ch = 0;
        model_frame("after_rst", 16'h0000, 16, 1'b0);
        model_frame("after_rst2", 16'h0000, 16, 1'b0);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            lft = 12'($urandom); rght = 12'($urandom);
            steer = 12'($urandom); batt = 12'($urandom);
            sel = int'($urandom_range(0, 7));
            model_frame($sformatf("rand%0d", i), 16'($urandom),
                        (sel == 0) ? 9 : ((sel == 1) ? 17 : 16),
                        1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
